param_data_mem: RTL and testbench

- Parametrised single-port data memory; next generation of the processor's data RAM.
- Adds byte-lane write enables, a valid/ready request port and a registered response with out-of-range error.
- Replaces the single-cycle whole-array reset clear with a sequential clear engine that sweeps one word per cycle.
- Sits between the MEM pipeline stage and the data array; the pipeline stalls on req_ready low.

---
 rtl/param_data_mem.sv | 101 ++++++++++
 tb/tb_param_data_mem.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/param_data_mem.sv
// Purpose: single-port data RAM with byte-lane writes, range checking and a sequential clear sweep.
// Latency: one cycle from an accepted request to its rsp_valid pulse (read data is registered).
// Backpressure: req_ready is low while the clear sweep runs; a request presented then is held by the requester.
//
// Ports:
//   clk, rst      - clock and synchronous active-high reset (reset starts a full clear sweep)
//   clr_start     - one-cycle pulse, re-zeroes the array; ignored while a sweep is already running
//   req_*         - valid/ready request: we, word addr, wdata, per-byte write enables
//   rsp_*         - registered response: valid pulse, read data (0 for writes/errors), out-of-range error
//   busy          - clear sweep in progress
module param_data_mem #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 8192,
    localparam int LANES = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_start,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [LANES-1:0]  req_be,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy
);

    localparam int IDX_W = $clog2(DEPTH);

    // One extra bit so DEPTH == 2**ADDR_W is representable.
    localparam logic [ADDR_W:0]  DEPTH_A  = (ADDR_W + 1)'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_IDLE  = 1'b1;

    logic [0:0]        state;
    logic [IDX_W-1:0]  ptr;
    logic [DATA_W-1:0] mem [DEPTH];

    logic             accept;
    logic             in_range;
    logic [IDX_W-1:0] idx;

    assign busy      = (state == ST_CLEAR);
    assign req_ready = (state == ST_IDLE);
    assign accept    = req_valid && req_ready;
    assign in_range  = ({1'b0, req_addr} < DEPTH_A);
    // Only meaningful when in_range; out-of-range requests never touch the array.
    assign idx       = req_addr[IDX_W-1:0];

    // Control state and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_CLEAR;
            ptr       <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= accept;
            rsp_err   <= accept && !in_range;
            if (accept && !req_we && in_range) begin
                rsp_rdata <= mem[idx];
            end else begin
                rsp_rdata <= '0;
            end

            if (state == ST_CLEAR) begin
                ptr <= ptr + 1'b1;
                if (ptr == LAST_IDX) begin
                    state <= ST_IDLE;
                end
            end else if (clr_start) begin
                // A request accepted on this same edge still completes below.
                state <= ST_CLEAR;
                ptr   <= '0;
            end
        end
    end

    // Array: no reset, so it maps onto RAM; zeroing is done by the sweep.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == ST_CLEAR) begin
                mem[ptr] <= '0;
            end else if (accept && req_we && in_range) begin
                for (int i = 0; i < LANES; i++) begin
                    if (req_be[i]) begin
                        mem[idx][8*i +: 8] <= req_wdata[8*i +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_param_data_mem.sv
module tb_param_data_mem;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clr_start = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [15:0] req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic [1:0]  req_be = '0;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    param_data_mem #(.DATA_W(16), .ADDR_W(16), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .clr_start(clr_start),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: expected responses {err, rdata}, array image, remaining clear cycles.
    logic [16:0] exp_q[$];
    logic [15:0] mdl [DEPTH];
    int          clr_left = 0;
    bit          started = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: check outputs of the previous edge, then drive inputs for the next edge.
    task automatic tick(input logic r, input logic v, input logic we, input logic [15:0] a,
                        input logic [15:0] wd, input logic [1:0] be, input logic clr,
                        output logic acc);
        logic [16:0] e;
        @(negedge clk);
        if (started) begin
            check("busy", busy, clr_left != 0);
            check("req_ready", req_ready, clr_left == 0);
            check("rsp_valid", rsp_valid, exp_q.size() != 0);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("rsp_rdata", rsp_rdata, e[15:0]);
                check("rsp_err", rsp_err, e[16]);
            end
        end
        rst = r; req_valid = v; req_we = we; req_addr = a;
        req_wdata = wd; req_be = be; clr_start = clr;
        acc = !r && v && started && (clr_left == 0);
        if (acc) begin
            if (a >= DEPTH) begin
                exp_q.push_back({1'b1, 16'h0000});
            end else if (we) begin
                if (be[0]) mdl[a][7:0]  = wd[7:0];
                if (be[1]) mdl[a][15:8] = wd[15:8];
                exp_q.push_back({1'b0, 16'h0000});
            end else begin
                exp_q.push_back({1'b0, mdl[a]});
            end
        end
        if (r) begin
            clr_left = DEPTH;
            started  = 1'b1;
            foreach (mdl[i]) mdl[i] = '0;
        end else if (clr_left != 0) begin
            clr_left--;
        end else if (clr) begin
            clr_left = DEPTH;
            foreach (mdl[i]) mdl[i] = '0;
        end
    endtask

    task automatic idle(input int n, input logic clr = 1'b0);
        logic acc;
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 2'b00, clr, acc);
    endtask

    task automatic do_reset(input int n);
        logic acc;
        for (int i = 0; i < n; i++) tick(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 2'b00, 1'b0, acc);
    endtask

    // Holds the request until accepted, bounded.
    task automatic req(input logic we, input logic [15:0] a, input logic [15:0] wd,
                       input logic [1:0] be, input logic clr = 1'b0);
        logic acc;
        int   n = 0;
        do begin
            tick(1'b0, 1'b1, we, a, wd, be, clr, acc);
            n++;
        end while (!acc && n < 100);
        check("req_accept", acc, 1);
    endtask

    initial begin
        // Reset sweep; busy/ready checked every cycle against the model.
        do_reset(2);
        idle(DEPTH);
        for (int i = 0; i < DEPTH; i++) req(1'b0, 16'(i), 16'h0, 2'b00);

        // Full write then read back.
        req(1'b1, 16'd5, 16'hBEEF, 2'b11);
        req(1'b0, 16'd5, 16'h0, 2'b00);

        // Byte-lane masked writes.
        req(1'b1, 16'd5, 16'h1234, 2'b01);
        req(1'b0, 16'd5, 16'h0, 2'b00);
        req(1'b1, 16'd5, 16'hAA00, 2'b10);
        req(1'b0, 16'd5, 16'h0, 2'b00);
        req(1'b1, 16'd7, 16'h9999, 2'b00);
        req(1'b0, 16'd7, 16'h0, 2'b00);

        // Out of range: no aliasing onto addr 0.
        req(1'b1, 16'd16, 16'hFFFF, 2'b11);
        req(1'b0, 16'd16, 16'h0, 2'b00);
        req(1'b0, 16'd0, 16'h0, 2'b00);
        req(1'b0, 16'hFFFF, 16'h0, 2'b00);

        // clr_start together with an accepted write; the read is held through the sweep.
        req(1'b1, 16'd3, 16'h5555, 2'b11, 1'b1);
        req(1'b0, 16'd3, 16'h0, 2'b00);
        req(1'b0, 16'd5, 16'h0, 2'b00);

        // Reset mid-sweep at ptr=7; clr_start during the sweep is ignored.
        idle(1, 1'b1);
        idle(3);
        idle(1, 1'b1);
        idle(3);
        do_reset(1);
        idle(DEPTH);

        // Back-to-back writes then reads of 1,2,3 on consecutive cycles.
        req(1'b1, 16'd1, 16'h1111, 2'b11);
        req(1'b1, 16'd2, 16'h2222, 2'b11);
        req(1'b1, 16'd3, 16'h3333, 2'b11);
        req(1'b0, 16'd1, 16'h0, 2'b00);
        req(1'b0, 16'd2, 16'h0, 2'b00);
        req(1'b0, 16'd3, 16'h0, 2'b00);
        req(1'b0, 16'd15, 16'h0, 2'b00);
        idle(3);

        check("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
